// File: rtl/seq_tx_if.sv
// seq_tx_if -- handshake and serial-output bundle for seq_tx.
//
// Signals:
//   start    request to begin a transmission (only looked at while the block is idle)
//   pattern  PAT_W-bit pattern, sent MSB first, captured with start
//   count    number of frames minus one, captured with start
//   x        serial data bit, 0 whenever x_valid is 0
//   x_valid  high on every cycle x carries a frame bit
//   busy     high while bits are being shifted out
//   done     one-cycle pulse after the last bit of the last frame
//
// Modports:
//   master  requester side: drives start/pattern/count, observes the outputs
//   slave   seq_tx side: observes the request, drives the outputs
interface seq_tx_if #(
    parameter int unsigned PAT_W = 4
) ();
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [3:0]       count;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, count,
        input  x, x_valid, busy, done
    );

    modport slave (
        input  start, pattern, count,
        output x, x_valid, busy, done
    );
endinterface

// File: rtl/seq_tx.sv
// seq_tx -- repeats a PAT_W-bit pattern (count+1) times on a serial output, MSB first.
//
// Ports:
//   clock  single clock, all state changes on its rising edge
//   reset  synchronous, active-high; returns to idle and clears all outputs and counters
//   bus    seq_tx_if.slave: start/pattern/count in, x/x_valid/busy/done out
//
// Behaviour: start is accepted only in idle; the first bit appears the next cycle. Frames
// follow each other with no gaps. After the final bit there is one done cycle, then idle.
// All outputs come straight from flops.
//
// Build option:
//   SEQ_TX_PARITY_EN  when defined, each frame is followed by one even-parity bit (XOR of
//                     the pattern bits), so a frame is PAT_W+1 bits instead of PAT_W.
module seq_tx #(
    parameter int unsigned PAT_W = 4
) (
    input logic   clock,
    input logic   reset,
    seq_tx_if.slave bus
);

`ifdef SEQ_TX_PARITY_EN
    localparam int unsigned FrameLen = PAT_W + 1;
`else
    localparam int unsigned FrameLen = PAT_W;
`endif
    localparam int unsigned IdxW = $clog2(FrameLen);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameLen - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [3:0]       frame_q, frame_d;   // frames still to send after the current one
    logic [IdxW-1:0]  idx_q, idx_d;       // position of the bit currently on x
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Bit at position idx of a frame: pattern bits MSB first, then parity if enabled.
    function automatic logic frame_bit(input logic [PAT_W-1:0] pat, input logic [IdxW-1:0] idx);
        logic [PAT_W-1:0] sh;
`ifdef SEQ_TX_PARITY_EN
        if (idx == IdxW'(PAT_W)) begin
            return ^pat;
        end
`endif
        sh = pat << idx;
        return sh[PAT_W-1];
    endfunction

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StShift;
                    pat_d     = bus.pattern;
                    frame_d   = bus.count;
                    idx_d     = '0;
                    // Output flops load the first bit now so it is visible next cycle.
                    x_d       = frame_bit(bus.pattern, '0);
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            StShift: begin
                if (idx_q == LastIdx) begin
                    idx_d = '0;
                    if (frame_q == 4'd0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        frame_d   = frame_q - 4'd1;
                        x_d       = frame_bit(pat_q, '0);
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end else begin
                    idx_d     = idx_q + IdxW'(1);
                    x_d       = frame_bit(pat_q, idx_q + IdxW'(1));
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            frame_q   <= '0;
            idx_q     <= '0;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = x_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx -- self-checking bench for seq_tx (PAT_W = 4).
// Fixed vectors carry hand-written expected bit streams; random transactions are checked
// against a frame-list model. Follows SEQ_TX_PARITY_EN the same way as the design.
module tb_seq_tx;
    localparam int unsigned PAT_W = 4;
`ifdef SEQ_TX_PARITY_EN
    localparam int F = PAT_W + 1;
`else
    localparam int F = PAT_W;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    seq_tx_if #(.PAT_W(PAT_W)) bus ();

    seq_tx #(.PAT_W(PAT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Observed outputs packed as {x, x_valid, busy, done}.
    logic [3:0] obs;
    assign obs = {bus.x, bus.x_valid, bus.busy, bus.done};

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    typedef struct {
        logic [3:0]  pat;
        logic [3:0]  cnt;
        int          len;
        logic [63:0] bits;   // expected stream, first bit in bits[len-1]
        int          poke;   // bit index at which start is re-pulsed, -1 for none
    } vec_t;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got x/v/b/d=%b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected stream: count+1 copies of the frame, each frame = pattern MSB..LSB [+ parity].
    function automatic void build(input logic [3:0] pat, input logic [3:0] cnt);
        exp_q.delete();
        for (int f = 0; f <= int'(cnt); f++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(pat[b]);
`ifdef SEQ_TX_PARITY_EN
            exp_q.push_back(^pat);
`endif
        end
    endfunction

    // Sends one transaction and checks every cycle against exp_q, the done pulse and idle.
    task automatic run_tx(input string tag, input logic [3:0] pat, input logic [3:0] cnt,
                          input int poke_at);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.pattern = pat;
        bus.count   = cnt;
        step();
        bus.start   = 1'b0;
        bus.pattern = 4'($urandom);
        bus.count   = 4'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s bit%0d", tag, i), obs, {exp_q[i], 3'b110});
            if (i == poke_at) begin
                bus.start   = 1'b1;
                bus.pattern = 4'b0110;
                bus.count   = 4'd3;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        check($sformatf("%s done", tag), obs, 4'b0001);
        step();
        check($sformatf("%s idle", tag), obs, 4'b0000);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        int   gap;
        int   poke;
        logic [3:0] rp;
        logic [3:0] rc;

`ifdef SEQ_TX_PARITY_EN
        vecs[0] = '{4'b1001, 4'd0, 5,  64'b10010, -1};
        vecs[1] = '{4'b1011, 4'd1, 10, 64'b10111_10111, -1};
        vecs[2] = '{4'b0110, 4'd1, 10, 64'b01100_01100, -1};
        vecs[3] = '{4'b1001, 4'd0, 5,  64'b10010, 1};
        vecs[4] = '{4'b1100, 4'd3, 20, 64'b11000_11000_11000_11000, 5};
`else
        vecs[0] = '{4'b1001, 4'd0, 4,  64'b1001, -1};
        vecs[1] = '{4'b1001, 4'd2, 12, 64'b1001_1001_1001, -1};
        vecs[2] = '{4'b0110, 4'd1, 8,  64'b0110_0110, -1};
        vecs[3] = '{4'b1001, 4'd0, 4,  64'b1001, 1};
        vecs[4] = '{4'b1100, 4'd3, 16, 64'hCCCC, 5};
`endif

        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.count   = '0;
        reset       = 1'b1;
        step();
        step();
        check("reset state", obs, 4'b0000);
        reset = 1'b0;
        step();
        check("idle no start", obs, 4'b0000);

        // Fixed vectors with hand-written streams.
        foreach (vecs[v]) begin
            exp_q.delete();
            for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(vecs[v].bits[vecs[v].len - 1 - i]);
            run_tx($sformatf("vec%0d", v), vecs[v].pat, vecs[v].cnt, vecs[v].poke);
        end

        // Reset on the third bit of a frame aborts with no done pulse.
        @(negedge clock);
        bus.start   = 1'b1;
        bus.pattern = 4'b1001;
        bus.count   = 4'd1;
        step();
        bus.start = 1'b0;
        check("abort bit0", obs, 4'b1110);
        step();
        check("abort bit1", obs, 4'b0110);
        step();
        check("abort bit2", obs, 4'b0110);
        reset = 1'b1;
        step();
        check("abort reset", obs, 4'b0000);
        reset = 1'b0;
        for (int k = 0; k < 2 * F + 2; k++) begin
            check($sformatf("abort quiet%0d", k), obs, 4'b0000);
            step();
        end
        build(4'b1011, 4'd1);
        run_tx("after abort", 4'b1011, 4'd1, -1);

        // Start on the very first edge after reset deasserts.
        @(negedge clock);
        reset = 1'b1;
        step();
        reset = 1'b0;
        build(4'b0101, 4'd0);
        run_tx("post reset", 4'b0101, 4'd0, -1);

        // start held high: bursts separated by the DONE and IDLE cycles.
        build(4'b1001, 4'd0);
        @(negedge clock);
        bus.start   = 1'b1;
        bus.pattern = 4'b1001;
        bus.count   = 4'd0;
        step();
        for (int k = 0; k < 3 * (F + 2); k++) begin
            int ph;
            ph = k % (F + 2);
            if (ph < F) check($sformatf("held c%0d", k), obs, {exp_q[ph], 3'b110});
            else if (ph == F) check($sformatf("held c%0d", k), obs, 4'b0001);
            else check($sformatf("held c%0d", k), obs, 4'b0000);
            if (k == 3 * (F + 2) - 2) bus.start = 1'b0;
            step();
        end
        check("held stop", obs, 4'b0000);

        // Random transactions against the model, with random idle gaps and start re-pulses.
        for (int t = 0; t < 20; t++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                check($sformatf("rnd%0d gap%0d", t, g), obs, 4'b0000);
                step();
            end
            rp = 4'($urandom);
            rc = 4'($urandom_range(0, 15));
            build(rp, rc);
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, exp_q.size() - 1)) : -1;
            run_tx($sformatf("rnd%0d p%b c%0d", t, rp, rc), rp, rc, poke);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
